// File: rtl/fsm_mult_ctrl_param.sv
// Sequencing controller for the FP multiplier datapath: programmable settle and
// multiplier-latency counters, optional second normalise pass, registered exception code.
module fsm_mult_ctrl_param #(
  parameter int SETTLE_CYC = 1,
  parameter int MULT_LAT   = 2,
  parameter int ROUND_EN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  input  logic       zero_flag,
  input  logic       underflow_f,
  input  logic       overflow_cout,
  input  logic       overflow_comp_a,
  input  logic       overflow_comp_b,
  output logic       rst_int,
  output logic       load_0,
  output logic       load_op,
  output logic       load_uf_sum,
  output logic       load_uf_info,
  output logic       load_exp_bias,
  output logic       load_exp_info,
  output logic       load_pre_mult,
  output logic       load_mult,
  output logic       load_sgf,
  output logic       load_exp_upd,
  output logic       load_exp_ov,
  output logic       load_round,
  output logic       sel_sgf_a,
  output logic       sel_exp_b,
  output logic       sel_final,
  output logic       sel_ovf,
  output logic       load_res_a,
  output logic       load_res_b,
  output logic       ready,
  output logic       busy,
  output logic [1:0] exc_code
);

  typedef enum logic [4:0] {
    IDLE, LOAD_OP, ZCHK, ZDEC, UF_SUM, UF_INFO, UF_DEC, EXP_BIAS, EXP_INFO, OV_DEC,
    PRE_MULT, MULT_WAIT, LOAD_MULT, SGF, EXP_UPD, EXP_OV, OV2_DEC, ROUND,
    FINAL_A, FINAL_B, EXC_A, EXC_B, DONE
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE      = 2'b00,
    EXC_ZERO      = 2'b01,
    EXC_UNDERFLOW = 2'b10,
    EXC_OVERFLOW  = 2'b11
  } exc_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
  localparam logic [3:0] LAT_LOAD    = 4'(MULT_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  exc_e       exc_code_q, exc_code_d;
  logic       pass_q, pass_d;
  logic       settle_hold;

  // States that idle SETTLE_CYC cycles before their single strobe cycle.
  function automatic logic is_settle(input state_e s);
    case (s)
      ZCHK, UF_SUM, UF_INFO, EXP_BIAS, EXP_INFO,
      SGF, EXP_UPD, EXP_OV, FINAL_A: is_settle = 1'b1;
      default:                       is_settle = 1'b0;
    endcase
  endfunction

  assign settle_hold = is_settle(state_q) && (settle_cnt_q != 4'd0);
  assign exc_code    = exc_code_q;

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    exc_code_d    = exc_code_q;
    pass_d        = pass_q;
    load_0        = 1'b0;
    load_op       = 1'b0;
    load_uf_sum   = 1'b0;
    load_uf_info  = 1'b0;
    load_exp_bias = 1'b0;
    load_exp_info = 1'b0;
    load_pre_mult = 1'b0;
    load_mult     = 1'b0;
    load_sgf      = 1'b0;
    load_exp_upd  = 1'b0;
    load_exp_ov   = 1'b0;
    load_round    = 1'b0;
    load_res_a    = 1'b0;
    load_res_b    = 1'b0;

    rst_int   = (state_q == IDLE);
    ready     = (state_q == DONE);
    busy      = (state_q != IDLE) && (state_q != DONE);
    sel_sgf_a = (state_q == SGF) && pass_q;
    sel_exp_b = ((state_q == SGF) || (state_q == EXP_UPD)) && pass_q;
    sel_final = (state_q == FINAL_A) || (state_q == FINAL_B);
    sel_ovf   = ((state_q == EXC_A) || (state_q == EXC_B)) && (exc_code_q == EXC_OVERFLOW);

    if (settle_hold) begin
      settle_cnt_d = settle_cnt_q - 4'd1;
    end else begin
      unique case (state_q)
        IDLE:      if (start) state_d = LOAD_OP;
        LOAD_OP: begin
          load_op    = 1'b1;
          exc_code_d = EXC_NONE;
          pass_d     = 1'b0;
          state_d    = ZCHK;
        end
        ZCHK:      begin load_0 = 1'b1; state_d = ZDEC; end
        ZDEC: begin
          if (zero_flag) begin
            exc_code_d = EXC_ZERO;
            state_d    = DONE;
          end else begin
            state_d = UF_SUM;
          end
        end
        UF_SUM:    begin load_uf_sum = 1'b1; state_d = UF_INFO; end
        UF_INFO:   begin load_uf_info = 1'b1; state_d = UF_DEC; end
        UF_DEC: begin
          if (underflow_f) begin
            exc_code_d = EXC_UNDERFLOW;
            state_d    = EXC_A;
          end else begin
            state_d = EXP_BIAS;
          end
        end
        EXP_BIAS:  begin load_exp_bias = 1'b1; state_d = EXP_INFO; end
        EXP_INFO:  begin load_exp_info = 1'b1; state_d = OV_DEC; end
        OV_DEC: begin
          if (overflow_cout || overflow_comp_a) begin
            exc_code_d = EXC_OVERFLOW;
            state_d    = EXC_A;
          end else begin
            state_d = PRE_MULT;
          end
        end
        PRE_MULT: begin
          load_pre_mult = 1'b1;
          lat_cnt_d     = LAT_LOAD;
          state_d       = MULT_WAIT;
        end
        MULT_WAIT: begin
          if (lat_cnt_q == 4'd0) state_d = LOAD_MULT;
          else                   lat_cnt_d = lat_cnt_q - 4'd1;
        end
        LOAD_MULT: begin load_mult = 1'b1; state_d = SGF; end
        SGF:       begin load_sgf = 1'b1; state_d = EXP_UPD; end
        EXP_UPD:   begin load_exp_upd = 1'b1; state_d = EXP_OV; end
        EXP_OV:    begin load_exp_ov = 1'b1; state_d = OV2_DEC; end
        OV2_DEC: begin
          if (overflow_comp_b) begin
            exc_code_d = EXC_OVERFLOW;
            state_d    = EXC_A;
          end else if ((ROUND_EN != 0) && !pass_q) begin
            state_d = ROUND;
          end else begin
            state_d = FINAL_A;
          end
        end
        // Second normalise pass re-enters SGF with the rounded significand selected.
        ROUND: begin
          load_round = 1'b1;
          pass_d     = 1'b1;
          state_d    = SGF;
        end
        FINAL_A:   begin load_res_a = 1'b1; state_d = FINAL_B; end
        FINAL_B:   begin load_res_b = 1'b1; state_d = DONE; end
        EXC_A:     begin load_res_a = 1'b1; state_d = EXC_B; end
        EXC_B:     begin load_res_b = 1'b1; state_d = DONE; end
        DONE:      if (ack) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end

    if ((state_d != state_q) && is_settle(state_d)) settle_cnt_d = SETTLE_LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= 4'd0;
      lat_cnt_q    <= 4'd0;
      exc_code_q   <= EXC_NONE;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      exc_code_q   <= exc_code_d;
      pass_q       <= pass_d;
    end
  end

  logic [13:0] load_vec;
  assign load_vec = {load_0, load_op, load_uf_sum, load_uf_info, load_exp_bias, load_exp_info,
                     load_pre_mult, load_mult, load_sgf, load_exp_upd, load_exp_ov, load_round,
                     load_res_a, load_res_b};

  a_one_strobe: assert property (@(posedge clk) disable iff (!rst) $onehot0(load_vec));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst) !(ready && busy));

endmodule

// File: tb/tb_fsm_mult_ctrl_param.sv
// Bench for fsm_mult_ctrl_param: four parameterisations, table vectors, handshake/abort
// sequences and random operations checked against a cycle-list reference model.
module tb_fsm_mult_ctrl_param;

  localparam int B_RST_INT = 20, B_LOAD_0 = 19, B_LOAD_OP = 18, B_UF_SUM = 17, B_UF_INFO = 16;
  localparam int B_EXP_BIAS = 15, B_EXP_INFO = 14, B_PRE_MULT = 13, B_LOAD_MULT = 12;
  localparam int B_SGF = 11, B_EXP_UPD = 10, B_EXP_OV = 9, B_ROUND = 8, B_SEL_SGF_A = 7;
  localparam int B_SEL_EXP_B = 6, B_SEL_FINAL = 5, B_SEL_OVF = 4, B_RES_A = 3, B_RES_B = 2;
  localparam int B_READY = 1, B_BUSY = 0;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] start_v, ack_v, zf_v, uf_v, co_v, ca_v, cb_v;
  wire  [3:0][20:0] out_w;
  wire  [3:0][1:0]  exc_w;

  int n_checks = 0;
  int n_err    = 0;

  logic [20:0] exp_q[$];
  logic [1:0]  exp_exc;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic rst_int, load_0, load_op, load_uf_sum, load_uf_info, load_exp_bias, load_exp_info;
    logic load_pre_mult, load_mult, load_sgf, load_exp_upd, load_exp_ov, load_round;
    logic sel_sgf_a, sel_exp_b, sel_final, sel_ovf, load_res_a, load_res_b, ready, busy;
    logic [1:0] exc_code;

    fsm_mult_ctrl_param #(
      .SETTLE_CYC(g == 1 ? 0 : 1),
      .MULT_LAT  (g == 3 ? 5 : 2),
      .ROUND_EN  (g == 2 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .ack(ack_v[g]), .zero_flag(zf_v[g]),
      .underflow_f(uf_v[g]), .overflow_cout(co_v[g]), .overflow_comp_a(ca_v[g]),
      .overflow_comp_b(cb_v[g]), .rst_int(rst_int), .load_0(load_0), .load_op(load_op),
      .load_uf_sum(load_uf_sum), .load_uf_info(load_uf_info), .load_exp_bias(load_exp_bias),
      .load_exp_info(load_exp_info), .load_pre_mult(load_pre_mult), .load_mult(load_mult),
      .load_sgf(load_sgf), .load_exp_upd(load_exp_upd), .load_exp_ov(load_exp_ov),
      .load_round(load_round), .sel_sgf_a(sel_sgf_a), .sel_exp_b(sel_exp_b),
      .sel_final(sel_final), .sel_ovf(sel_ovf), .load_res_a(load_res_a),
      .load_res_b(load_res_b), .ready(ready), .busy(busy), .exc_code(exc_code)
    );

    assign out_w[g] = {rst_int, load_0, load_op, load_uf_sum, load_uf_info, load_exp_bias,
                       load_exp_info, load_pre_mult, load_mult, load_sgf, load_exp_upd,
                       load_exp_ov, load_round, sel_sgf_a, sel_exp_b, sel_final, sel_ovf,
                       load_res_a, load_res_b, ready, busy};
    assign exc_w[g] = exc_code;
  end

  function automatic int sc_of(input int i); return (i == 1) ? 0 : 1; endfunction
  function automatic int ml_of(input int i); return (i == 3) ? 5 : 2; endfunction
  function automatic bit re_of(input int i); return (i == 2) ? 1'b0 : 1'b1; endfunction
  function automatic logic [20:0] bw(input int b); return 21'd1 << b; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: the list of expected output words, one per cycle from LOAD_OP to DONE.
  task automatic settle_strobe(input int settle, input logic [20:0] base, input int strobe_bit);
    repeat (settle) exp_q.push_back(base);
    exp_q.push_back(base | bw(strobe_bit));
  endtask

  task automatic exc_tail(input logic [1:0] code);
    logic [20:0] ovf;
    ovf     = (code == 2'b11) ? bw(B_SEL_OVF) : 21'd0;
    exp_exc = code;
    exp_q.push_back(bw(B_BUSY) | ovf | bw(B_RES_A));
    exp_q.push_back(bw(B_BUSY) | ovf | bw(B_RES_B));
    exp_q.push_back(bw(B_READY));
  endtask

  task automatic build_trace(input int sc, input int ml, input bit re,
                             input bit zf, input bit uf, input bit co, input bit ca,
                             input bit cb1, input bit cb2);
    logic [20:0] bz;
    logic [20:0] s1;
    bz = bw(B_BUSY);
    exp_q.delete();
    exp_q.push_back(bz | bw(B_LOAD_OP));
    settle_strobe(sc, bz, B_LOAD_0);
    exp_q.push_back(bz);
    if (zf) begin
      exp_exc = 2'b01;
      exp_q.push_back(bw(B_READY));
      return;
    end
    settle_strobe(sc, bz, B_UF_SUM);
    settle_strobe(sc, bz, B_UF_INFO);
    exp_q.push_back(bz);
    if (uf) begin exc_tail(2'b10); return; end
    settle_strobe(sc, bz, B_EXP_BIAS);
    settle_strobe(sc, bz, B_EXP_INFO);
    exp_q.push_back(bz);
    if (co || ca) begin exc_tail(2'b11); return; end
    exp_q.push_back(bz | bw(B_PRE_MULT));
    repeat (ml) exp_q.push_back(bz);
    exp_q.push_back(bz | bw(B_LOAD_MULT));
    for (int p = 0; p < 2; p++) begin
      s1 = (p == 1) ? bw(B_SEL_EXP_B) : 21'd0;
      settle_strobe(sc, bz | s1 | ((p == 1) ? bw(B_SEL_SGF_A) : 21'd0), B_SGF);
      settle_strobe(sc, bz | s1, B_EXP_UPD);
      settle_strobe(sc, bz, B_EXP_OV);
      exp_q.push_back(bz);
      if ((p == 0) ? cb1 : cb2) begin exc_tail(2'b11); return; end
      if (!re || p == 1) break;
      exp_q.push_back(bz | bw(B_ROUND));
    end
    settle_strobe(sc, bz | bw(B_SEL_FINAL), B_RES_A);
    exp_q.push_back(bz | bw(B_SEL_FINAL) | bw(B_RES_B));
    exp_q.push_back(bw(B_READY));
    exp_exc = 2'b00;
  endtask

  // Runs one operation on instance i. Entry/exit at #1 after a posedge with the DUT in IDLE
  // (or left in DONE when do_ack is 0). Start is high during cycle 0, so LOAD_OP owns cycle 1.
  task automatic run_op(input int i, input bit zf, input bit uf, input bit co, input bit ca,
                        input bit cb1, input bit cb2, input bit ack_busy, input int hold,
                        input bit do_ack, input string nm,
                        output int rdy_edge, output int mult_edge, output logic [1:0] exc_done);
    logic [20:0] mm_a, mm_e;
    int mm_k;
    bit mm, rnd_seen;
    build_trace(sc_of(i), ml_of(i), re_of(i), zf, uf, co, ca, cb1, cb2);
    check({nm, " idle"}, 32'(out_w[i]), 32'(bw(B_RST_INT)));
    zf_v[i] = zf; uf_v[i] = uf; co_v[i] = co; ca_v[i] = ca; cb_v[i] = cb1;
    start_v[i] = 1'b1;
    rdy_edge = -1; mult_edge = -1; mm = 1'b0; rnd_seen = 1'b0; mm_k = 0;
    mm_a = '0; mm_e = '0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      if (exp_q[k][B_ROUND]) rnd_seen = 1'b1;
      cb_v[i]  = rnd_seen ? cb2 : cb1;
      ack_v[i] = ack_busy && exp_q[k][B_BUSY];
      if (out_w[i][B_READY] && rdy_edge < 0) rdy_edge = k + 1;
      if (out_w[i][B_LOAD_MULT] && mult_edge < 0) mult_edge = k + 1;
      if (!mm && (out_w[i] !== exp_q[k])) begin
        mm = 1'b1; mm_a = out_w[i]; mm_e = exp_q[k]; mm_k = k + 1;
      end
    end
    if (!mm) begin
      mm_a = out_w[i]; mm_e = exp_q[exp_q.size() - 1]; mm_k = exp_q.size();
    end
    check($sformatf("%s trace@cycle%0d", nm, mm_k), 32'(mm_a), 32'(mm_e));
    exc_done = exc_w[i];
    zf_v[i] = 1'b0; uf_v[i] = 1'b0; co_v[i] = 1'b0; ca_v[i] = 1'b0; cb_v[i] = 1'b0;
    ack_v[i] = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      check({nm, " done hold"}, 32'(out_w[i]), 32'(bw(B_READY)));
    end
    if (do_ack) begin
      ack_v[i] = 1'b1;
      @(posedge clk); #1;
      ack_v[i] = 1'b0;
      check({nm, " ack->idle"}, 32'(out_w[i]), 32'(bw(B_RST_INT)));
    end
  endtask

  typedef struct {
    int         inst;
    bit         zf, uf, co, ca, cb1, cb2, ack_busy;
    int         exp_ready;
    int         exp_mult;
    logic [1:0] exp_exc;
    string      name;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy, me, ri;
    logic [1:0] ex;
    bit zf, uf, co, ca, cb1, cb2, ab;

    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 37, 18, 2'b00, "normal"};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0,  5, -1, 2'b01, "zero"};
    tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 12, -1, 2'b10, "underflow"};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 17, -1, 2'b11, "ovf_cout"};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 0, 17, -1, 2'b11, "ovf_comp_a"};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, 28, 18, 2'b11, "ovf_comp_b_pass0"};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 36, 18, 2'b11, "ovf_comp_b_pass1"};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 25, 13, 2'b00, "settle0_normal"};
    tbl[8]  = '{2, 0, 0, 0, 0, 0, 0, 0, 29, 18, 2'b00, "noround_normal"};
    tbl[9]  = '{2, 0, 0, 0, 0, 0, 1, 0, 29, 18, 2'b00, "noround_comp_b"};
    tbl[10] = '{3, 0, 0, 0, 0, 0, 0, 0, 40, 21, 2'b00, "multlat5_normal"};
    tbl[11] = '{0, 1, 1, 0, 0, 0, 0, 1,  5, -1, 2'b01, "zero_wins_ackbusy"};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 37, 18, 2'b00, "normal_ackbusy"};
    tbl[13] = '{1, 0, 1, 0, 0, 0, 0, 0,  9, -1, 2'b10, "settle0_underflow"};

    rst = 1'b0;
    start_v = '0; ack_v = '0; zf_v = '0; uf_v = '0; co_v = '0; ca_v = '0; cb_v = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset outputs inst%0d", i), 32'(out_w[i]), 32'(bw(B_RST_INT)));
      check($sformatf("reset exc inst%0d", i), 32'(exc_w[i]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 14; t++) begin
      run_op(tbl[t].inst, tbl[t].zf, tbl[t].uf, tbl[t].co, tbl[t].ca, tbl[t].cb1, tbl[t].cb2,
             tbl[t].ack_busy, 1, 1'b1, tbl[t].name, rdy, me, ex);
      check({tbl[t].name, " ready edge"}, 32'(rdy), 32'(tbl[t].exp_ready));
      check({tbl[t].name, " load_mult edge"}, 32'(me), 32'(tbl[t].exp_mult));
      check({tbl[t].name, " exc_code"}, 32'(ex), 32'(tbl[t].exp_exc));
    end

    // Reset while parked in DONE with an overflow code clears the code at once.
    run_op(0, 0, 0, 1, 0, 0, 0, 0, 0, 1'b0, "ovf_then_reset", rdy, me, ex);
    check("ovf_then_reset exc before", 32'(ex), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("reset in done outputs", 32'(out_w[0]), 32'(bw(B_RST_INT)));
    check("reset in done exc", 32'(exc_w[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // start held with ack in DONE: one IDLE cycle, then a fresh operation; abort it in MULT_WAIT.
    run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "start_held", rdy, me, ex);
    start_v[0] = 1'b1;
    ack_v[0]   = 1'b1;
    @(posedge clk); #1;
    ack_v[0] = 1'b0;
    check("start_held one idle", 32'(out_w[0]), 32'(bw(B_RST_INT)));
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("start_held restart", 32'(out_w[0]), 32'(bw(B_BUSY) | bw(B_LOAD_OP)));
    repeat (15) @(posedge clk);
    #1;
    check("abort in mult_wait", 32'(out_w[0]), 32'(bw(B_BUSY)));
    #2 rst = 1'b0;
    #1;
    check("abort outputs", 32'(out_w[0]), 32'(bw(B_RST_INT)));
    check("abort exc", 32'(exc_w[0]), 32'd0);
    @(posedge clk); #1;
    check("abort held", 32'(out_w[0]), 32'(bw(B_RST_INT)));
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort stays idle", 32'(out_w[0]), 32'(bw(B_RST_INT)));

    for (int n = 0; n < 40; n++) begin
      ri  = $urandom_range(0, 3);
      zf  = ($urandom_range(0, 5) == 0);
      uf  = ($urandom_range(0, 5) == 0);
      co  = ($urandom_range(0, 7) == 0);
      ca  = ($urandom_range(0, 7) == 0);
      cb1 = ($urandom_range(0, 7) == 0);
      cb2 = ($urandom_range(0, 2) == 0);
      ab  = ($urandom_range(0, 1) == 1);
      run_op(ri, zf, uf, co, ca, cb1, cb2, ab, $urandom_range(0, 2), 1'b1,
             $sformatf("rnd%0d_inst%0d", n, ri), rdy, me, ex);
      check($sformatf("rnd%0d ready edge", n), 32'(rdy), 32'(exp_q.size()));
      check($sformatf("rnd%0d exc_code", n), 32'(ex), 32'(exp_exc));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_mult_ctrl_param.md
Name: fsm_mult_ctrl_param

Overview:
- Parametrised sequencing controller for the FP multiplier datapath. Successor to the fixed-state multiply FSM.
- Fixed "give time" states are replaced by a programmable settle counter, plus a multiplier-latency wait counter.
- The rounding/renormalise pass is optional, and a registered exception code is added.
- Drives datapath load/select strobes. Handshakes with the issuing unit via start/ack.

Parameters:
- SETTLE_CYC, 1, idle cycles before each settle-type load pulse (0..15).
- MULT_LAT, 2, cycles between load_pre_mult and load_mult (1..15).
- ROUND_EN, 1, 1 = run the second normalise pass after rounding; 0 = skip it.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin operation; sampled only in IDLE.
- ack  in  1  result acknowledge; sampled only in DONE.
- zero_flag  in  1  operand-zero detect.
- underflow_f  in  1  exponent underflow.
- overflow_cout  in  1  exponent-add carry-out.
- overflow_comp_a  in  1  exponent > max, first check.
- overflow_comp_b  in  1  exponent > max, after update.
- rst_int  out  1  datapath internal clear.
- load_0  out  1  strobe: zero-info register.
- load_op  out  1  strobe: operand registers.
- load_uf_sum  out  1  strobe: underflow exponent sum.
- load_uf_info  out  1  strobe: underflow flag register.
- load_exp_bias  out  1  strobe: biased exponent.
- load_exp_info  out  1  strobe: exponent/overflow info.
- load_pre_mult  out  1  strobe: multiplier inputs.
- load_mult  out  1  strobe: product register.
- load_sgf  out  1  strobe: normalised significand.
- load_exp_upd  out  1  strobe: updated exponent.
- load_exp_ov  out  1  strobe: overflow compare register.
- load_round  out  1  strobe: rounded significand.
- sel_sgf_a  out  1  significand mux: 1 = rounded value.
- sel_exp_b  out  1  exponent mux: 1 = second-pass source.
- sel_final  out  1  final-result mux: normal result.
- sel_ovf  out  1  final-result mux: overflow code.
- load_res_a  out  1  strobe: result stage A.
- load_res_b  out  1  strobe: result stage B.
- ready  out  1  result valid.
- busy  out  1  operation in flight.
- exc_code  out  2  00 none, 01 zero, 10 underflow, 11 overflow.

Behaviour:
- Single always-block state register; outputs are combinational from state, except exc_code and pass, which are registered.
- Reset (rst=0): state=IDLE, exc_code=00, pass=0, counters=0. All outputs are 0 except rst_int=1. Reset asserted mid-operation aborts immediately to IDLE; no further strobes.
- S-state: holds SETTLE_CYC cycles with no strobe, then 1 cycle with its strobe, then advances. With SETTLE_CYC=0 it is a 1-cycle strobe state. One shared counter, reloaded on each S-state entry.
- Sequence:
  - IDLE: rst_int=1. If start, go to LOAD_OP.
  - LOAD_OP: load_op=1; clear exc_code and pass.
  - ZCHK(S, load_0), then ZDEC. ZDEC: if zero_flag, exc=01 and go to DONE; else UF_SUM.
  - UF_SUM(S, load_uf_sum), then UF_INFO(S, load_uf_info), then UF_DEC. UF_DEC: if underflow_f, exc=10 and go to EXC_A; else EXP_BIAS.
  - EXP_BIAS(S), then EXP_INFO(S), then OV_DEC. OV_DEC: if overflow_cout or overflow_comp_a, exc=11 and go to EXC_A; else PRE_MULT.
  - PRE_MULT: load_pre_mult, 1 cycle. Then MULT_WAIT for MULT_LAT cycles. Then LOAD_MULT: load_mult, 1 cycle.
  - Normalise pass: SGF(S), EXP_UPD(S), EXP_OV(S), then OV2_DEC. OV2_DEC: if overflow_comp_b, exc=11 and go to EXC_A; else if ROUND_EN and pass=0, go to ROUND; else FINAL_A.
  - ROUND: load_round, 1 cycle; set pass=1; return to SGF.
  - pass=1: sel_sgf_a=1 in SGF; sel_exp_b=1 in SGF and EXP_UPD.
  - FINAL_A(S, load_res_a), then FINAL_B(load_res_b). sel_final=1 in both. Then DONE.
  - EXC_A: load_res_a. EXC_B: load_res_b. sel_ovf=(exc_code==11) in both. Then DONE.
  - DONE: ready=1. If ack, go to IDLE.
- busy=1 in every state except IDLE and DONE.
- start outside IDLE is ignored. ack outside DONE is ignored.
- start and ack both high in DONE: go to IDLE; start is not consumed and must be re-sampled in IDLE.
- Timing convention: start sampled at edge 0; a state entered at edge k owns cycle k.
- Latency to DONE entry (ready high), defaults: normal path edge 37; zero edge 5; underflow edge 12; first-overflow edge 17.
- SETTLE_CYC=0 normal path: edge 25. ROUND_EN=0 (SETTLE_CYC=1) normal path: edge 29.
- Every load strobe is exactly 1 cycle wide. No two load strobes are ever high in the same cycle.

Test Plan:
- Reset held then released; pulse start. Expect rst_int=1 in IDLE. Normal path: ready rises at edge 37, exc_code=00. Strobe order and one-cycle widths are checked against the sequence. ack returns to IDLE.
- zero_flag=1: ready at edge 5, exc_code=01, no load_res_a/b strobes.
- underflow_f=1: exc_code=10, EXC_A/EXC_B strobes with sel_ovf=0, ready at edge 12.
- overflow_cout=1: exc_code=11, sel_ovf=1 during EXC_A/B, ready at edge 17. Also overflow_comp_b=1 only during the second pass: exc=11 via OV2_DEC.
- Parameter sweep {SETTLE_CYC=0, ROUND_EN=1} gives ready at edge 25; {SETTLE_CYC=1, ROUND_EN=0} gives ready at edge 29 and no load_round; MULT_LAT=5 shifts load_mult by +3 cycles.
- Abort and handshake corners:
  - rst asserted during MULT_WAIT: all strobes drop the same cycle, busy=0, exc_code=00.
  - start held through DONE with ack: one IDLE cycle, then a new operation starts.
  - ack pulsed while busy: ignored.
